// File: rtl/fx3_stream_in_writer_if.sv
// Valid/ready word stream from the capture-side source into the FX3 stream-in writer.
// The master modport is the source; the slave modport is the writer.
interface fx3_stream_in_writer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fx3_stream_in_writer.sv
// FX3 slave-FIFO write engine: drains a valid/ready stream into one socket, honours the
// watermark with a post-watermark drain, and commits short packets on flush or idle timeout.
module fx3_stream_in_writer #(
   parameter int         DATA_W    = 32,
   parameter int         WATERMARK = 4,
   parameter logic [1:0] ADDR      = 2'b00,
   parameter int         PKT_WORDS = 256,
   parameter int         IDLE_TO   = 1024,
   parameter bit         ALLOW_ZLP = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   fx3_stream_in_writer_if.slave s_if,
   input  logic                  flush,
   input  logic                  flag_rdy,
   input  logic                  flag_wm,
   output logic                  slcs_n,
   output logic                  slwr_n,
   output logic                  sloe_n,
   output logic                  slrd_n,
   output logic                  pktend_n,
   output logic [1:0]            a,
   output logic [DATA_W-1:0]     dq,
   output logic                  dq_oe,
   output logic [2:0]            state_o,
   output logic                  busy
);

   localparam int WR_DELAY = (WATERMARK > 4) ? WATERMARK - 4 : 0;
   localparam int DRAIN_W  = (WR_DELAY > 1) ? $clog2(WR_DELAY + 1) : 1;
   localparam int PKT_W    = $clog2(PKT_WORDS);
   localparam int TO_W     = (IDLE_TO > 1) ? $clog2(IDLE_TO + 1) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_WM = 3'd1,
      WRITE   = 3'd2,
      DRAIN   = 3'd3,
      PKTEND  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                flush_pend_q, flush_pend_d;
   logic                slcs_n_q, slcs_n_d;
   logic                slwr_n_q, slwr_n_d;
   logic                pktend_n_q, pktend_n_d;
   logic                dq_oe_q, dq_oe_d;
   logic [DATA_W-1:0]   dq_q, dq_d;
   logic                s_ready_c;
   logic                accept;
   logic                to_hit;

   // Ready is gated by enable so a word is never accepted in a cycle that aborts to IDLE.
   always_comb begin
      s_ready_c = 1'b0;
      if (enable) begin
         case (state_q)
            WRITE:   s_ready_c = flag_wm;
            DRAIN:   s_ready_c = (drain_cnt_q != '0);
            default: s_ready_c = 1'b0;
         endcase
      end
   end

   assign s_if.s_ready = s_ready_c;
   assign accept       = s_if.s_valid && s_ready_c;
   assign to_hit       = (IDLE_TO != 0) && (state_q == WRITE) && (to_cnt_q == TO_W'(IDLE_TO));

   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      pkt_cnt_d    = pkt_cnt_q;
      to_cnt_d     = to_cnt_q;
      flush_pend_d = flush_pend_q;

      case (state_q)
         IDLE: begin
            if (flag_rdy) state_d = WAIT_WM;
         end
         WAIT_WM: begin
            if (flag_wm)                       state_d = WRITE;
            else if (flush_pend_q && flag_rdy) state_d = PKTEND;
         end
         WRITE: begin
            if (!flag_wm) begin
               if (WR_DELAY == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_W'(WR_DELAY);
               end
            end else if (flush_pend_q && !accept) begin
               state_d = PKTEND;
            end
         end
         DRAIN: begin
            if (drain_cnt_q == '0) state_d = IDLE;
            else if (accept)       drain_cnt_d = drain_cnt_q - 1'b1;
         end
         PKTEND:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         pkt_cnt_d = pkt_cnt_q + 1'b1;
         to_cnt_d  = '0;
      end else if (state_q == WRITE && pkt_cnt_q != '0 && to_cnt_q != TO_W'(IDLE_TO)) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      if (state_q == PKTEND) begin
         pkt_cnt_d    = '0;
         to_cnt_d     = '0;
         flush_pend_d = 1'b0;
      end

      if (flush || to_hit) flush_pend_d = 1'b1;
      // A full buffer wrapping to zero was already committed by FX3, so nothing is left to flush.
      if (!ALLOW_ZLP && pkt_cnt_d == '0) flush_pend_d = 1'b0;

      if (!enable) begin
         state_d      = IDLE;
         drain_cnt_d  = '0;
         pkt_cnt_d    = '0;
         to_cnt_d     = '0;
         flush_pend_d = 1'b0;
      end

      slcs_n_d   = !enable;
      slwr_n_d   = !accept;
      dq_d       = accept ? s_if.s_data : dq_q;
      pktend_n_d = (state_d != PKTEND);
      dq_oe_d    = (state_d != IDLE) || accept;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         drain_cnt_q  <= '0;
         pkt_cnt_q    <= '0;
         to_cnt_q     <= '0;
         flush_pend_q <= 1'b0;
         slcs_n_q     <= 1'b1;
         slwr_n_q     <= 1'b1;
         pktend_n_q   <= 1'b1;
         dq_oe_q      <= 1'b0;
         dq_q         <= '0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         pkt_cnt_q    <= pkt_cnt_d;
         to_cnt_q     <= to_cnt_d;
         flush_pend_q <= flush_pend_d;
         slcs_n_q     <= slcs_n_d;
         slwr_n_q     <= slwr_n_d;
         pktend_n_q   <= pktend_n_d;
         dq_oe_q      <= dq_oe_d;
         dq_q         <= dq_d;
      end
   end

   assign slcs_n   = slcs_n_q;
   assign slwr_n   = slwr_n_q;
   assign sloe_n   = 1'b1;
   assign slrd_n   = 1'b1;
   assign pktend_n = pktend_n_q;
   assign a        = ADDR;
   assign dq       = dq_q;
   assign dq_oe    = dq_oe_q;
   assign state_o  = state_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fx3_stream_in_writer.sv
// Directed bench: three writers (A: 32b WM4 timeout16 ZLP, B: 32b WM6 no-timeout no-ZLP,
// C: 16b WM4 ZLP) share control inputs; each has its own counting source and strobe monitor.
module tb_fx3_stream_in_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n     = 1'b0;
   logic enable    = 1'b0;
   logic flag_rdy  = 1'b0;
   logic flag_wm   = 1'b0;
   logic flush     = 1'b0;
   logic src_valid = 1'b0;

   int check_count = 0;
   int error_count = 0;
   int cycle_count = 0;

   fx3_stream_in_writer_if #(.DATA_W(32)) ifc_a ();
   fx3_stream_in_writer_if #(.DATA_W(32)) ifc_b ();
   fx3_stream_in_writer_if #(.DATA_W(16)) ifc_c ();

   logic        slcs_n_w [3];
   logic        slwr_n_w [3];
   logic        sloe_n_w [3];
   logic        slrd_n_w [3];
   logic        pktend_n_w [3];
   logic        dq_oe_w [3];
   logic        busy_w [3];
   logic        rdy_w [3];
   logic [1:0]  a_w [3];
   logic [2:0]  state_w [3];
   logic [31:0] dq_w [3];
   logic [31:0] dq_a, dq_b;
   logic [15:0] dq_c;

   int acc [3];
   int strb [3];
   int pkt [3];
   int last_strb_cyc [3];
   int pkt_cyc [3];

   function automatic logic [31:0] base_of(input int i);
      case (i)
         0:       return 32'hA000_0000;
         1:       return 32'hB000_0000;
         default: return 32'h0000_C000;
      endcase
   endfunction

   function automatic logic [1:0] addr_of(input int i);
      case (i)
         0:       return 2'b00;
         1:       return 2'b10;
         default: return 2'b01;
      endcase
   endfunction

   assign ifc_a.s_valid = src_valid;
   assign ifc_b.s_valid = src_valid;
   assign ifc_c.s_valid = src_valid;
   assign ifc_a.s_data  = base_of(0) + 32'(acc[0]);
   assign ifc_b.s_data  = base_of(1) + 32'(acc[1]);
   assign ifc_c.s_data  = 16'(base_of(2) + 32'(acc[2]));
   assign rdy_w[0]      = ifc_a.s_ready;
   assign rdy_w[1]      = ifc_b.s_ready;
   assign rdy_w[2]      = ifc_c.s_ready;
   assign dq_w[0]       = dq_a;
   assign dq_w[1]       = dq_b;
   assign dq_w[2]       = {16'h0000, dq_c};

   fx3_stream_in_writer #(.DATA_W(32), .WATERMARK(4), .ADDR(2'b00), .PKT_WORDS(256),
                          .IDLE_TO(16), .ALLOW_ZLP(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(ifc_a), .flush(flush),
      .flag_rdy(flag_rdy), .flag_wm(flag_wm), .slcs_n(slcs_n_w[0]), .slwr_n(slwr_n_w[0]),
      .sloe_n(sloe_n_w[0]), .slrd_n(slrd_n_w[0]), .pktend_n(pktend_n_w[0]), .a(a_w[0]),
      .dq(dq_a), .dq_oe(dq_oe_w[0]), .state_o(state_w[0]), .busy(busy_w[0]));

   fx3_stream_in_writer #(.DATA_W(32), .WATERMARK(6), .ADDR(2'b10), .PKT_WORDS(256),
                          .IDLE_TO(0), .ALLOW_ZLP(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(ifc_b), .flush(flush),
      .flag_rdy(flag_rdy), .flag_wm(flag_wm), .slcs_n(slcs_n_w[1]), .slwr_n(slwr_n_w[1]),
      .sloe_n(sloe_n_w[1]), .slrd_n(slrd_n_w[1]), .pktend_n(pktend_n_w[1]), .a(a_w[1]),
      .dq(dq_b), .dq_oe(dq_oe_w[1]), .state_o(state_w[1]), .busy(busy_w[1]));

   fx3_stream_in_writer #(.DATA_W(16), .WATERMARK(4), .ADDR(2'b01), .PKT_WORDS(256),
                          .IDLE_TO(0), .ALLOW_ZLP(1'b1)) dut_c (
      .clk(clk), .rst_n(rst_n), .enable(enable), .s_if(ifc_c), .flush(flush),
      .flag_rdy(flag_rdy), .flag_wm(flag_wm), .slcs_n(slcs_n_w[2]), .slwr_n(slwr_n_w[2]),
      .sloe_n(sloe_n_w[2]), .slrd_n(slrd_n_w[2]), .pktend_n(pktend_n_w[2]), .a(a_w[2]),
      .dq(dq_c), .dq_oe(dq_oe_w[2]), .state_o(state_w[2]), .busy(busy_w[2]));

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   always @(posedge clk) cycle_count++;

   // Each source presents base+n and advances only on a completed handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) acc[i] <= 0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (src_valid && rdy_w[i]) acc[i] <= acc[i] + 1;
      end
   end

   // Every strobe must carry the next source word in order; PKTEND never overlaps a strobe.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            strb[i] = 0;
            pkt[i]  = 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!slwr_n_w[i]) begin
               checkOutput($sformatf("dq_word%0d", i), dq_w[i], base_of(i) + 32'(strb[i]));
               checkOutput($sformatf("oe_on_strobe%0d", i), 32'(dq_oe_w[i]), 1);
               strb[i]++;
               last_strb_cyc[i] = cycle_count;
            end
            if (!pktend_n_w[i]) begin
               checkOutput($sformatf("pktend_no_strobe%0d", i), 32'(slwr_n_w[i]), 1);
               pkt[i]++;
               pkt_cyc[i] = cycle_count;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic wm,
                                input logic vld, input logic fl, input int n);
      enable    = en;
      flag_rdy  = rdy;
      flag_wm   = wm;
      src_valid = vld;
      flush     = fl;
      tick(n);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic waitAccepted(input string tag, input int target, input int budget);
      int n = 0;
      while (acc[0] < target && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput(tag, 32'(acc[0]), 32'(target));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int gap;
      int n;

      // Reset values on every writer
      rst_n = 1'b0;
      tick(3);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("rst_slcs%0d", i), 32'(slcs_n_w[i]), 1);
         checkOutput($sformatf("rst_slwr%0d", i), 32'(slwr_n_w[i]), 1);
         checkOutput($sformatf("rst_sloe%0d", i), 32'(sloe_n_w[i]), 1);
         checkOutput($sformatf("rst_slrd%0d", i), 32'(slrd_n_w[i]), 1);
         checkOutput($sformatf("rst_pktend%0d", i), 32'(pktend_n_w[i]), 1);
         checkOutput($sformatf("rst_addr%0d", i), 32'(a_w[i]), 32'(addr_of(i)));
         checkOutput($sformatf("rst_dq%0d", i), dq_w[i], 0);
         checkOutput($sformatf("rst_dqoe%0d", i), 32'(dq_oe_w[i]), 0);
         checkOutput($sformatf("rst_state%0d", i), 32'(state_w[i]), 0);
         checkOutput($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 0);
      end
      rst_n = 1'b1;
      tick(1);

      // Watermark after 100 words: A/C stop at once, B drains 2 more around a source gap
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      waitAccepted("wm_reach100", 100, 200);
      checkOutput("slcs_active", 32'(slcs_n_w[0]), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      #1;
      checkOutput("ready_drop_a", 32'(rdy_w[0]), 0);
      checkOutput("ready_drop_c", 32'(rdy_w[2]), 0);
      tick(5);
      checkOutput("strobes_a100", 32'(strb[0]), 100);
      checkOutput("state_a_idle", 32'(state_w[0]), 0);
      checkOutput("state_b_drain", 32'(state_w[1]), 3);
      checkOutput("state_c_idle", 32'(state_w[2]), 0);
      checkOutput("dqoe_a_idle", 32'(dq_oe_w[0]), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6);
      checkOutput("acc_b_drain", 32'(acc[1]), 102);
      checkOutput("strobes_b102", 32'(strb[1]), 102);
      checkOutput("state_b_idle", 32'(state_w[1]), 0);
      checkOutput("busy_b_idle", 32'(busy_w[1]), 0);
      checkOutput("strobes_c100", 32'(strb[2]), 100);
      checkOutput("acc_a_stop", 32'(acc[0]), 100);

      // Ten words then flush: one short-packet commit on every writer, then ZLP behaviour
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      waitAccepted("flush_reach10", 10, 50);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
      for (int i = 0; i < 3; i++)
         checkOutput($sformatf("flush_pkt%0d", i), 32'(pkt[i]), 1);
      checkOutput("flush_strobes", 32'(strb[0]), 10);
      gap = pkt_cyc[0] - last_strb_cyc[0];
      checkOutput("pktend_after_strobe", 32'(gap >= 1), 1);
      tick(30);
      checkOutput("pktcnt_cleared_no_to", 32'(pkt[0]), 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
      checkOutput("zlp_a", 32'(pkt[0]), 2);
      checkOutput("no_zlp_b", 32'(pkt[1]), 1);
      checkOutput("zlp_c", 32'(pkt[2]), 2);
      checkOutput("zlp_no_strobes", 32'(strb[0]), 10);

      // Idle timeout on A after 5 words; B and C have it disabled
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      waitAccepted("to_reach5", 5, 50);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      n = 0;
      while (pkt[0] == 0 && n < 60) begin
         tick(1);
         n++;
      end
      checkOutput("to_pktend_a", 32'(pkt[0]), 1);
      gap = pkt_cyc[0] - last_strb_cyc[0];
      checkOutput("to_delay_window", 32'(gap >= 16 && gap <= 20), 1);
      tick(30);
      checkOutput("to_single_a", 32'(pkt[0]), 1);
      checkOutput("to_none_b", 32'(pkt[1]), 0);
      checkOutput("to_none_c", 32'(pkt[2]), 0);

      // Full 256-word buffer wraps the packet count with no PKTEND
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      waitAccepted("wrap_reach256", 256, 400);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 30);
      checkOutput("wrap_strobes", 32'(strb[0]), 256);
      checkOutput("wrap_no_pkt_a", 32'(pkt[0]), 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
      checkOutput("wrap_zlp_a", 32'(pkt[0]), 1);
      checkOutput("wrap_no_pkt_b", 32'(pkt[1]), 0);

      // enable dropped mid-WRITE: abort to IDLE, last registered word still strobes
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      waitAccepted("abort_reach7", 7, 50);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2);
      checkOutput("abort_state", 32'(state_w[0]), 0);
      checkOutput("abort_busy", 32'(busy_w[0]), 0);
      checkOutput("abort_dqoe", 32'(dq_oe_w[0]), 0);
      checkOutput("abort_slcs", 32'(slcs_n_w[0]), 1);
      checkOutput("abort_slwr", 32'(slwr_n_w[0]), 1);
      checkOutput("abort_strobes", 32'(strb[0]), 7);
      checkOutput("abort_acc", 32'(acc[0]), 7);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 30);
      checkOutput("abort_no_to", 32'(pkt[0]), 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
      checkOutput("abort_cleared_b", 32'(pkt[1]), 0);

      // Asynchronous reset mid-packet, sampled with no clock edge in between
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      waitAccepted("areset_reach3", 3, 50);
      checkOutput("areset_pre_strobe", 32'(slwr_n_w[0]), 0);
      rst_n = 1'b0;
      #1;
      checkOutput("areset_slwr", 32'(slwr_n_w[0]), 1);
      checkOutput("areset_dq", dq_w[0], 0);
      checkOutput("areset_dqoe", 32'(dq_oe_w[0]), 0);
      checkOutput("areset_state", 32'(state_w[0]), 0);
      checkOutput("areset_slcs", 32'(slcs_n_w[0]), 1);
      checkOutput("areset_dq_c", dq_w[2], 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, error_count);
      $finish;
   end

endmodule
